// File: rtl/cpu_pkg.sv
// Shared types for the CPU program loader: word type, loader FSM states, IMEM address helper.
package cpu_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] instr_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_RUN,
    ST_HALTED,
    ST_ERROR
  } loader_state_t;

  // Byte address of word idx; wraps modulo 2^32 by construction.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/imem_stream_loader_xor_acc.sv
// Running 32-bit XOR accumulator used to verify the program checksum word.
module loader_xor_acc
  import cpu_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_clear,
  input  logic   i_en,
  input  instr_t i_data,
  output instr_t o_acc
);

  instr_t r_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_acc <= '0;
    else if (i_clear) r_acc <= '0;
    else if (i_en)    r_acc <= r_acc ^ i_data;
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/imem_stream_loader.sv
// Streams instruction words into IMEM, holds the CPU in reset while loading, then releases it.
// Optional checksum trailer word enabled by defining LOADER_CHECKSUM_EN.
module imem_stream_loader
  import cpu_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          CNT_W       = $clog2(DEPTH_WORDS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  instr_t           in_data,
  input  logic             in_last,
  output logic             imem_we,
  output logic [31:0]      imem_addr,
  output instr_t           imem_wdata,
  output logic             cpu_rst_n,
  input  logic             halt,
  output logic             busy,
  output logic             error,
  output logic [CNT_W-1:0] word_count
);

  loader_state_t    r_state;
  logic             r_in_ready;
  logic             r_imem_we;
  logic [31:0]      r_imem_addr;
  instr_t           r_imem_wdata;
  logic             r_cpu_rst_n;
  logic             r_busy;
  logic             r_error;
  logic [CNT_W-1:0] r_word_count;

  logic w_accept, w_is_chk, w_full, w_write, w_overflow, w_start_ok, w_chk_fail;

  assign w_accept   = (r_state == ST_LOAD) && in_valid && r_in_ready;
  assign w_full     = (r_word_count == CNT_W'(DEPTH_WORDS));
  assign w_write    = w_accept && !w_is_chk && !w_full;
  assign w_overflow = w_accept && !w_is_chk && w_full;
  assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_HALTED) ||
                                (r_state == ST_ERROR));

`ifdef LOADER_CHECKSUM_EN
  instr_t r_expected;
  instr_t w_acc;

  // The in_last beat carries the expected checksum rather than program data.
  assign w_is_chk   = in_last;
  assign w_chk_fail = (w_acc != r_expected);

  loader_xor_acc u_xor_acc (
    .clk     (clk),
    .rst_n   (rst),
    .i_clear (w_start_ok),
    .i_en    (w_write),
    .i_data  (in_data),
    .o_acc   (w_acc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     r_expected <= '0;
    else if (w_accept && in_last) r_expected <= in_data;
  end
`else
  assign w_is_chk   = 1'b0;
  assign w_chk_fail = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_in_ready   <= 1'b0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
      r_cpu_rst_n  <= 1'b0;
      r_busy       <= 1'b0;
      r_error      <= 1'b0;
      r_word_count <= '0;
    end else begin
      r_imem_we <= w_write;
      if (w_write) begin
        r_imem_addr  <= word_addr(BASE_ADDR, 32'(r_word_count));
        r_imem_wdata <= in_data;
        r_word_count <= r_word_count + 1'b1;
      end

      unique case (r_state)
        ST_IDLE, ST_HALTED, ST_ERROR: begin
          if (w_start_ok) begin
            r_state      <= ST_LOAD;
            r_in_ready   <= 1'b1;
            r_busy       <= 1'b1;
            r_error      <= 1'b0;
            r_word_count <= '0;
          end
        end
        ST_LOAD: begin
          if (w_overflow) begin
            r_state    <= ST_ERROR;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_error    <= 1'b1;
          end else if (w_accept && in_last) begin
            r_state    <= ST_CHECK;
            r_in_ready <= 1'b0;
          end
        end
        ST_CHECK: begin
          r_busy <= 1'b0;
          if (w_chk_fail) begin
            r_state <= ST_ERROR;
            r_error <= 1'b1;
          end else begin
            r_state     <= ST_RUN;
            r_cpu_rst_n <= 1'b1;
          end
        end
        ST_RUN: begin
          if (halt) begin
            r_state     <= ST_HALTED;
            r_cpu_rst_n <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign imem_we    = r_imem_we;
  assign imem_addr  = r_imem_addr;
  assign imem_wdata = r_imem_wdata;
  assign cpu_rst_n  = r_cpu_rst_n;
  assign busy       = r_busy;
  assign error      = r_error;
  assign word_count = r_word_count;

endmodule

// File: tb/tb_imem_stream_loader.sv
// Self-checking bench for imem_stream_loader: table-driven loads, random loads vs a queue model,
// halt/reload and mid-load reset sequences. Honours LOADER_CHECKSUM_EN if defined.
module tb_imem_stream_loader;
  import cpu_pkg::*;

  localparam int          DEPTH = 8;
  localparam logic [31:0] BASE  = 32'hFFFF_FFF0;
  localparam int          CW    = $clog2(DEPTH + 1);
`ifdef LOADER_CHECKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  instr_t        in_data = '0;
  logic          in_last = 1'b0;
  logic          imem_we;
  logic [31:0]   imem_addr;
  instr_t        imem_wdata;
  logic          cpu_rst_n;
  logic          halt = 1'b0;
  logic          busy;
  logic          error;
  logic [CW-1:0] word_count;

  imem_stream_loader #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_rst_n(cpu_rst_n), .halt(halt), .busy(busy),
    .error(error), .word_count(word_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write monitor: every IMEM write seen between edges, with its cycle number.
  int          cyc = 0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
      wr_cyc.push_back(cyc);
    end
  end

  // Reference model: what a load of word list w must produce.
  logic [31:0] cur_w[$];
  logic [31:0] ex_addr[$];
  logic [31:0] ex_data[$];
  int          ex_cnt;
  bit          ex_err;
  bit          ex_ovf;
  int          ex_beats;

  task automatic model();
    int          nd;
    logic [31:0] x;
    ex_addr.delete();
    ex_data.delete();
    ex_ovf = 1'b0;
    x      = '0;
    nd     = CHK ? cur_w.size() - 1 : cur_w.size();
    for (int i = 0; i < nd; i++) begin
      if (i == DEPTH) begin
        ex_ovf = 1'b1;
        break;
      end
      ex_addr.push_back(BASE + 32'(4 * i));
      ex_data.push_back(cur_w[i]);
      x = x ^ cur_w[i];
    end
    ex_cnt   = ex_addr.size();
    ex_err   = ex_ovf || (CHK && (x != cur_w[cur_w.size()-1]));
    ex_beats = ex_ovf ? DEPTH + 1 : cur_w.size();
  endtask

  task automatic build(input int n, input int kind, input bit corrupt);
    logic [31:0] x;
    cur_w.delete();
    x = '0;
    for (int i = 0; i < n; i++) begin
      logic [31:0] v;
      if (kind == 0)      v = 32'h0000_0013 + 32'(i << 7);
      else if (kind == 1) v = 32'(i + 1);
      else                v = $urandom;
      if (CHK && i == n - 1) v = x ^ (corrupt ? 32'h7 : 32'h0);
      x = x ^ v;
      cur_w.push_back(v);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Drive cur_w onto the stream until max_beats are accepted (bounded).
  task automatic stream(input bit gaps, input int max_beats, output int got);
    int guard = 0;
    got = 0;
    while (got < max_beats && guard < 300) begin
      guard++;
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = cur_w[got];
        in_last  = (got == cur_w.size() - 1);
      end
      if (in_valid && in_ready) got++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_load(input string tag, input bit gaps, input int exp_cnt, input int exp_err);
    int got;
    int nw;
    model();
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
    pulse_start();
    check({tag, " start in_ready"}, in_ready, 1);
    check({tag, " start busy"}, busy, 1);
    check({tag, " start count"}, word_count, 0);
    check({tag, " start error"}, error, 0);
    stream(gaps, ex_beats, got);
    check({tag, " beats accepted"}, got, ex_beats);
    check({tag, " busy after last"}, busy, !ex_ovf);
    check({tag, " cpu held after last"}, cpu_rst_n, 0);
    @(negedge clk);
    check({tag, " busy settled"}, busy, 0);
    check({tag, " cpu_rst_n"}, cpu_rst_n, !ex_err);
    check({tag, " error"}, error, ex_err);
    check({tag, " in_ready idle"}, in_ready, 0);
    check({tag, " word_count"}, word_count, ex_cnt);
    if (exp_cnt >= 0) begin
      check({tag, " table count"}, word_count, exp_cnt);
      check({tag, " table error"}, error, exp_err);
    end
    nw = wr_addr.size();
    check({tag, " write count"}, nw, ex_addr.size());
    for (int i = 0; i < nw && i < ex_addr.size(); i++) begin
      check($sformatf("%s wr%0d addr", tag, i), wr_addr[i], ex_addr[i]);
      check($sformatf("%s wr%0d data", tag, i), wr_data[i], ex_data[i]);
    end
    if (!gaps && nw > 1) check({tag, " back-to-back"}, wr_cyc[nw-1] - wr_cyc[0], nw - 1);
    // Stream and halt activity outside LOAD must have no effect on IMEM.
    in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    check({tag, " no stray writes"}, wr_addr.size(), nw);
    check({tag, " count held"}, word_count, ex_cnt);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    check({tag, " after halt cpu_rst_n"}, cpu_rst_n, 0);
    check({tag, " after halt error"}, error, ex_err);
    @(negedge clk);
    check({tag, " frozen cpu_rst_n"}, cpu_rst_n, 0);
  endtask

  typedef struct {
    int n;
    int kind;
    bit gaps;
    bit corrupt;
    int exp_cnt;
    bit exp_err;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int got;
`ifdef LOADER_CHECKSUM_EN
    tbl.push_back('{n: 3,         kind: 1, gaps: 0, corrupt: 0, exp_cnt: 2,     exp_err: 0});
    tbl.push_back('{n: 3,         kind: 1, gaps: 0, corrupt: 1, exp_cnt: 2,     exp_err: 1});
    tbl.push_back('{n: 1,         kind: 2, gaps: 0, corrupt: 0, exp_cnt: 0,     exp_err: 0});
    tbl.push_back('{n: DEPTH + 1, kind: 2, gaps: 0, corrupt: 0, exp_cnt: DEPTH, exp_err: 0});
    tbl.push_back('{n: DEPTH + 2, kind: 2, gaps: 1, corrupt: 0, exp_cnt: DEPTH, exp_err: 1});
    tbl.push_back('{n: 5,         kind: 0, gaps: 1, corrupt: 0, exp_cnt: 4,     exp_err: 0});
`else
    tbl.push_back('{n: 4,         kind: 0, gaps: 0, corrupt: 0, exp_cnt: 4,     exp_err: 0});
    tbl.push_back('{n: 1,         kind: 2, gaps: 0, corrupt: 0, exp_cnt: 1,     exp_err: 0});
    tbl.push_back('{n: DEPTH,     kind: 2, gaps: 0, corrupt: 0, exp_cnt: DEPTH, exp_err: 0});
    tbl.push_back('{n: DEPTH + 1, kind: 2, gaps: 0, corrupt: 0, exp_cnt: DEPTH, exp_err: 1});
    tbl.push_back('{n: 5,         kind: 1, gaps: 1, corrupt: 0, exp_cnt: 5,     exp_err: 0});
`endif

    // Reset state.
    repeat (2) @(negedge clk);
    check("reset cpu_rst_n", cpu_rst_n, 0);
    check("reset in_ready", in_ready, 0);
    check("reset imem_we", imem_we, 0);
    check("reset busy", busy, 0);
    check("reset error", error, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle in_ready", in_ready, 0);
    check("idle cpu_rst_n", cpu_rst_n, 0);

    foreach (tbl[v]) begin
      build(tbl[v].n, tbl[v].kind, tbl[v].corrupt);
      run_load($sformatf("vec%0d", v), tbl[v].gaps, tbl[v].exp_cnt, int'(tbl[v].exp_err));
    end

    // Reset dropped mid-load after two beats delivered with gaps.
    build(6, 2, 0);
    pulse_start();
    stream(1'b1, 2, got);
    check("midreset beats", got, 2);
    rst = 1'b0;
    #1;
    check("midreset imem_we", imem_we, 0);
    check("midreset in_ready", in_ready, 0);
    check("midreset busy", busy, 0);
    check("midreset count", word_count, 0);
    check("midreset cpu_rst_n", cpu_rst_n, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int r = 0; r < 12; r++) begin
      build($urandom_range(1, DEPTH + (CHK ? 2 : 1)), 2, ($urandom_range(0, 3) == 0));
      run_load($sformatf("rnd%0d", r), $urandom_range(0, 1), -1, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
